// File: rtl/sdram_scheduler.sv
// SDRAM command scheduler: arbitrates generator row reads, sampler row writes
// and auto-refresh onto a single command engine, one command in flight at a time.

module sdram_sched_chan (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic done,
    output logic ack,
    output logic eligible
);
    // Four-phase ack: rises after the channel's command completes, falls once req is seen low.
    always_ff @(posedge clk) begin
        if (reset)
            ack <= 1'b0;
        else if (ack && !req)
            ack <= 1'b0;
        else if (done)
            ack <= 1'b1;
    end

    assign eligible = req && !ack;
endmodule

module sdram_scheduler #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int MAX_PENDING      = 8,
    parameter int URGENT_PENDING   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_req,
    input  logic       s_cache_row,
    input  logic [9:0] s_sdram_row,
    output logic       s_ack,
    input  logic       g_req,
    input  logic       g_cache_row,
    input  logic [9:0] g_sdram_row,
    output logic       g_ack,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic       cmd_cache_row,
    output logic [9:0] cmd_sdram_row,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    output logic [3:0] refresh_pending,
    output logic       refresh_overrun
);
    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [1:0] OP_REFRESH = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;

    typedef struct packed {
        logic [1:0] op;
        logic       cache_row;
        logic [9:0] sdram_row;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t        state, state_nxt;
    cmd_t          cmd_q, cmd_nxt;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          urgent;
    logic          busy_done;
    logic          ref_done;
    // Channel index 0 = sampler (write), 1 = generator (read).
    logic [1:0]    ch_req, ch_done, ch_ack, ch_elig;

    assign ch_req     = {g_req, s_req};
    assign busy_done  = (state == BUSY) && cmd_done;
    assign ref_done   = busy_done && (cmd_q.op == OP_REFRESH);
    assign ch_done[0] = busy_done && (cmd_q.op == OP_WRITE);
    assign ch_done[1] = busy_done && (cmd_q.op == OP_READ);

    sdram_sched_chan u_chan [1:0] (
        .clk      (clk),
        .reset    (reset),
        .req      (ch_req),
        .done     (ch_done),
        .ack      (ch_ack),
        .eligible (ch_elig)
    );

    assign s_ack = ch_ack[0];
    assign g_ack = ch_ack[1];

    // Refresh interval timer; the wrap cycle is the tick.
    assign tick = (tick_cnt == TW'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // A tick and a refresh completion in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_pending <= '0;
            refresh_overrun <= 1'b0;
        end else if (tick && !ref_done) begin
            if (refresh_pending == 4'(MAX_PENDING))
                refresh_overrun <= 1'b1;
            else
                refresh_pending <= refresh_pending + 4'd1;
        end else if (ref_done && !tick) begin
            refresh_pending <= refresh_pending - 4'd1;
        end
    end

    assign urgent = (refresh_pending >= 4'(URGENT_PENDING));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cmd_q <= '0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
        end
    end

    // Fixed priority: urgent refresh, display read, sampler write, background refresh.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        case (state)
            IDLE: begin
                state_nxt = ISSUE;
                if (urgent)
                    cmd_nxt = '{op: OP_REFRESH, cache_row: 1'b0, sdram_row: 10'd0};
                else if (ch_elig[1])
                    cmd_nxt = '{op: OP_READ, cache_row: g_cache_row, sdram_row: g_sdram_row};
                else if (ch_elig[0])
                    cmd_nxt = '{op: OP_WRITE, cache_row: s_cache_row, sdram_row: s_sdram_row};
                else if (refresh_pending != 4'd0)
                    cmd_nxt = '{op: OP_REFRESH, cache_row: 1'b0, sdram_row: 10'd0};
                else
                    state_nxt = IDLE;
            end
            ISSUE: if (cmd_ready) state_nxt = BUSY;
            BUSY:  if (cmd_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_valid     = (state == ISSUE);
    assign cmd_op        = cmd_q.op;
    assign cmd_cache_row = cmd_q.cache_row;
    assign cmd_sdram_row = cmd_q.sdram_row;
endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed bench for sdram_scheduler: refresh timing, four-phase acks,
// priority, ready back-pressure, pending saturation and mid-command reset.

module tb_sdram_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_req = 1'b0, s_cache_row = 1'b0;
    logic [9:0] s_sdram_row = '0;
    logic       s_ack;
    logic       g_req = 1'b0, g_cache_row = 1'b0;
    logic [9:0] g_sdram_row = '0;
    logic       g_ack;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_cache_row;
    logic [9:0] cmd_sdram_row;
    logic       cmd_ready = 1'b1, cmd_done = 1'b0;
    logic [3:0] refresh_pending;
    logic       refresh_overrun;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cnt = 0;

    sdram_scheduler dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_cache_row(s_cache_row), .s_sdram_row(s_sdram_row), .s_ack(s_ack),
        .g_req(g_req), .g_cache_row(g_cache_row), .g_sdram_row(g_sdram_row), .g_ack(g_ack),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_cache_row(cmd_cache_row),
        .cmd_sdram_row(cmd_sdram_row), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .refresh_pending(refresh_pending), .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; accepted-command count.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (!cmd_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Expects cmd_ready=1; accepts the command, completes it 4 cycles after accept.
    task automatic serve(input string tag, input logic [1:0] op, input logic cr,
                         input logic [9:0] row, output int t_valid);
        wait_valid(tag, 2000);
        t_valid = cyc;
        check({tag, "_op"}, 32'(cmd_op), 32'(op));
        if (op != 2'b00) begin
            check({tag, "_cache"}, 32'(cmd_cache_row), 32'(cr));
            check({tag, "_row"}, 32'(cmd_sdram_row), 32'(row));
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(cmd_valid), 32'd0);
        repeat (3) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int  t, t0, acc0;
        logic flag;

        // 1: idle refresh cadence
        apply_reset();
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_pending", 32'(refresh_pending), 32'd0);
        check("rst_acks", 32'({s_ack, g_ack}), 32'd0);
        serve("ref1", 2'b00, 1'b0, 10'd0, t);
        check("ref1_cycle", 32'(t), 32'd781);
        check("ref1_pending", 32'(refresh_pending), 32'd0);
        serve("ref2", 2'b00, 1'b0, 10'd0, t);
        check("ref2_cycle", 32'(t), 32'd1561);
        wait_cyc(2000);
        check("idle_pending", 32'(refresh_pending), 32'd0);
        check("idle_overrun", 32'(refresh_overrun), 32'd0);

        // 2: sampler write handshake; stray cmd_done in IDLE is ignored
        apply_reset();
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("idle_done_pending", 32'(refresh_pending), 32'd0);
        check("idle_done_acks", 32'({s_ack, g_ack}), 32'd0);
        s_sdram_row = 10'h155; s_cache_row = 1'b1; s_req = 1'b1;
        t0 = cyc;
        serve("wr", 2'b01, 1'b1, 10'h155, t);
        check("wr_latency", 32'(t - t0), 32'd1);
        check("wr_ack_rise", 32'(s_ack), 32'd1);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) flag = 1'b1;
        end
        check("wr_no_repeat", 32'(flag), 32'd0);
        check("wr_ack_hold", 32'(s_ack), 32'd1);
        s_req = 1'b0;
        @(negedge clk);
        check("wr_ack_fall", 32'(s_ack), 32'd0);

        // 3a: simultaneous requests, read wins
        apply_reset();
        g_sdram_row = 10'h2AA; g_cache_row = 1'b0;
        s_sdram_row = 10'h0F3; s_cache_row = 1'b1;
        g_req = 1'b1; s_req = 1'b1;
        serve("pri_rd", 2'b10, 1'b0, 10'h2AA, t);
        check("pri_g_ack", 32'({g_ack, s_ack}), 32'b10);
        serve("pri_wr", 2'b01, 1'b1, 10'h0F3, t);
        check("pri_s_ack", 32'({g_ack, s_ack}), 32'b11);
        g_req = 1'b0; s_req = 1'b0;
        @(negedge clk);
        check("pri_acks_fall", 32'({g_ack, s_ack}), 32'd0);

        // 3b: urgent refresh preempts both: stall first refresh in BUSY to 7 pending
        apply_reset();
        wait_valid("urg_first", 1000);
        wait_cyc(5465);
        check("urg_pending7", 32'(refresh_pending), 32'd7);
        g_req = 1'b1; s_req = 1'b1;
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("urg_pending6", 32'(refresh_pending), 32'd6);
        serve("urg_ref", 2'b00, 1'b0, 10'd0, t);
        check("urg_pending5", 32'(refresh_pending), 32'd5);
        serve("urg_rd", 2'b10, 1'b0, 10'h2AA, t);
        serve("urg_wr", 2'b01, 1'b1, 10'h0F3, t);
        check("urg_acks", 32'({g_ack, s_ack}), 32'b11);
        g_req = 1'b0; s_req = 1'b0;

        // 4: back-pressure in ISSUE
        apply_reset();
        cmd_ready = 1'b0;
        s_sdram_row = 10'h155; s_cache_row = 1'b1; s_req = 1'b1;
        wait_valid("bp", 20);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!cmd_valid || cmd_op != 2'b01 || cmd_sdram_row != 10'h155 || !cmd_cache_row)
                flag = 1'b1;
        end
        check("bp_stable", 32'(flag), 32'd0);
        acc0 = acc_cnt;
        cmd_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(cmd_valid), 32'd0);
        repeat (3) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        check("bp_one_accept", 32'(acc_cnt - acc0), 32'd1);
        check("bp_ack", 32'(s_ack), 32'd1);
        s_req = 1'b0;
        @(negedge clk);

        // 5: refresh never completes -> saturation and sticky overrun
        apply_reset();
        wait_cyc(6245);
        check("sat_pending8", 32'(refresh_pending), 32'd8);
        check("sat_no_overrun", 32'(refresh_overrun), 32'd0);
        wait_cyc(7025);
        check("sat_hold8", 32'(refresh_pending), 32'd8);
        check("sat_overrun", 32'(refresh_overrun), 32'd1);
        wait_cyc(7805);
        check("sat_overrun_sticky", 32'(refresh_overrun), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("sat_rst_pending", 32'(refresh_pending), 32'd0);
        check("sat_rst_overrun", 32'(refresh_overrun), 32'd0);
        reset = 1'b0;

        // 6: reset while BUSY with a read in flight
        apply_reset();
        g_sdram_row = 10'h3C1; g_cache_row = 1'b1; g_req = 1'b1;
        wait_valid("mid", 20);
        check("mid_op", 32'(cmd_op), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_gack", 32'(g_ack), 32'd0);
        check("mid_rst_pending", 32'(refresh_pending), 32'd0);
        reset = 1'b0;
        serve("mid_rd", 2'b10, 1'b1, 10'h3C1, t);
        check("mid_gack", 32'(g_ack), 32'd1);
        g_req = 1'b0;
        @(negedge clk);
        check("mid_gack_fall", 32'(g_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
